time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Time-setting sequencer for the calendar clock. Turns two raw push-buttons (MODE, UP)
//  into the pause/field-increment controls of the time-keeping core, and the selected-field
//  and blink controls of the display. Sits between board buttons and main_control/display.
// PARAMETERS
//  DEBOUNCE_CYC     1_000_000  cycles a synced button must be stable before accepted
//  TIMEOUT_CYC    500_000_000  idle cycles in an edit state before auto-return to RUN
//  BLINK_HALF_CYC  25_000_000  half-period of the field blink
//  REPEAT_DELAY_CYC 25_000_000 UP hold time before auto-repeat starts (AUTOREPEAT_EN only)
//  REPEAT_RATE_CYC  5_000_000  cycles between auto-repeat pulses (AUTOREPEAT_EN only)
// PORTS
//  clk        in   1  system clock
//  rst_p      in   1  asynchronous reset, active-low
//  btn_mode   in   1  raw MODE button, active-high, asynchronous
//  btn_up     in   1  raw UP button, active-high, asynchronous
//  pause      out  1  1 = time-keeping core frozen (any edit state)
//  inc_sec    out  1  1-cycle increment pulse, seconds  (drives switch_second)
//  inc_min    out  1  1-cycle increment pulse, minutes  (switch_minute)
//  inc_hour   out  1  1-cycle increment pulse, hours    (switch_hour)
//  inc_day    out  1  1-cycle increment pulse, day      (switch_day)
//  inc_month  out  1  1-cycle increment pulse, month    (switch_month)
//  inc_year   out  1  1-cycle increment pulse, year     (switch_year)
//  sel_field  out  3  current state code (0 RUN, 1 SEC .. 6 YEAR)
//  field_vis  out  1  1 = selected field shown, 0 = blanked (blink phase)
// BEHAVIOUR
//  - Reset (rst_p=0, any time incl. mid-edit): state RUN; pause=0, all inc_*=0, sel_field=0,
//    field_vis=1; all counters 0; debounced levels 0. Takes effect immediately (async).
//  - Buttons: 2-flop sync, then counter; accepted level changes after DEBOUNCE_CYC consecutive
//    cycles of a stable differing synced value. press = rising edge of accepted level (1 cycle).
//  - FSM: RUN->SEC->MIN->HOUR->DAY->MONTH->YEAR->RUN, advancing one step per MODE press.
//    State, pause, sel_field registered: update in cycle after the press pulse.
//  - pause = (state != RUN), registered with state.
//  - UP press in edit state S: inc_<S> high for exactly one cycle, the cycle after the press.
//    UP press in RUN: ignored, no pulse. Only one inc_* ever high at a time.
//  - MODE and UP press in the same cycle: MODE wins, UP dropped (no inc pulse).
//  - Timeout: idle counter cleared on entering an edit state and on every MODE/UP press or
//    inc pulse; on reaching TIMEOUT_CYC-1 in an edit state -> RUN next cycle (pause falls).
//  - Blink: in RUN field_vis=1 constantly. In edit, toggles every BLINK_HALF_CYC cycles;
//    forced to 1 and blink counter cleared on state entry and on each inc pulse.
//  - Counters saturate-free: widths = $clog2(param+1); no wrap before terminal compare.
// CONFIGURATION
//  AUTOREPEAT_EN defined: while UP held (accepted level 1) in the same edit state, first
//    extra inc pulse REPEAT_DELAY_CYC cycles after the press pulse, then every REPEAT_RATE_CYC;
//    stops on release, state change or reset. Each repeat pulse clears idle and blink timers.
//  AUTOREPEAT_EN undefined: exactly one inc pulse per UP press; REPEAT_* unused.
// STRUCTURE
//  time_set_pkg: state enum/codes (ST_RUN=0..ST_YEAR=6), state width constant.
//  Sub-module btn_debounce (sync + debounce + rising-edge press), instantiated twice.
//  Top: FSM, inc decode, idle timer, blink timer, optional repeat timer.
// TESTING (DEBOUNCE_CYC=4, TIMEOUT_CYC=100, BLINK_HALF_CYC=8, REPEAT_DELAY=20, RATE=5)
//  1 Reset then idle 200 cyc -> pause=0, sel_field=0, field_vis=1, no inc pulse.
//  2 MODE pressed 7 times (held 10 cyc each) -> sel_field 1,2,3,4,5,6,0; pause 1 then 0.
//  3 sel=3, UP pulsed 3 times -> exactly 3 single-cycle inc_hour pulses, no other inc_*.
//  4 UP glitch 2 cyc high -> no press, no pulse; MODE+UP pressed same cycle -> state
//    advances, no inc.
//  5 sel=1, no buttons -> RUN after 100 cyc; field_vis toggles every 8 cyc until then.
//  6 AUTOREPEAT_EN, sel=6, UP held 50 cyc after press -> inc_year pulses at +1,+20,+25,
//    +30..; without macro -> one pulse. Reset asserted mid-hold -> all outputs reset values.

Source files
------------

// File: rtl/time_set_pkg.sv
// time_set_pkg: shared state codes for the time-setting sequencer.
// The state code doubles as the display's selected-field number, so the
// enum values are fixed: RUN is 0, SEC..YEAR are 1..6.
package time_set_pkg;

  localparam int ST_W       = 3;
  localparam int NUM_FIELDS = 6;

  typedef enum logic [ST_W-1:0] {
    ST_RUN   = 3'd0,
    ST_SEC   = 3'd1,
    ST_MIN   = 3'd2,
    ST_HOUR  = 3'd3,
    ST_DAY   = 3'd4,
    ST_MONTH = 3'd5,
    ST_YEAR  = 3'd6
  } state_t;

  // Successor in the MODE cycle RUN->SEC->...->YEAR->RUN.
  function automatic state_t next_field(input state_t s);
    case (s)
      ST_RUN:   return ST_SEC;
      ST_SEC:   return ST_MIN;
      ST_MIN:   return ST_HOUR;
      ST_HOUR:  return ST_DAY;
      ST_DAY:   return ST_MONTH;
      ST_MONTH: return ST_YEAR;
      default:  return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and press detector
// for one raw push-button. The accepted level only changes after the synced
// input has differed from it for DEBOUNCE_CYC consecutive cycles; press is a
// single-cycle pulse in the cycle the accepted level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_p,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync_a_reg;
  logic             sync_b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             press_reg;

  // Synchronise, count consecutive differing cycles, accept and flag rising edges.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      sync_a_reg <= 1'b0;
      sync_b_reg <= 1'b0;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
      press_reg  <= 1'b0;
    end else begin
      sync_a_reg <= btn;
      sync_b_reg <= sync_a_reg;
      press_reg  <= 1'b0;
      if (sync_b_reg != level_reg) begin
        if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level_reg <= sync_b_reg;
          press_reg <= sync_b_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: turns debounced MODE/UP presses into the pause and
// field-increment controls of the time core plus the display's field
// select and blink. MODE steps through RUN->SEC->...->YEAR->RUN; UP in an
// edit state emits one inc pulse for that field. An idle timer drops back
// to RUN, and a blink timer blanks the selected field periodically.
// Optional feature macro: AUTOREPEAT_EN -- holding UP produces repeat
// increments after REPEAT_DELAY_CYC, then every REPEAT_RATE_CYC.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int TIMEOUT_CYC      = 500_000_000,
  parameter int BLINK_HALF_CYC   = 25_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_p,
  input  logic            btn_mode,
  input  logic            btn_up,
  output logic            pause,
  output logic            inc_sec,
  output logic            inc_min,
  output logic            inc_hour,
  output logic            inc_day,
  output logic            inc_month,
  output logic            inc_year,
  output logic [ST_W-1:0] sel_field,
  output logic            field_vis
);

  localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_CYC + 1);

  state_t                state_reg;
  state_t                state_next;
  logic                  pause_reg;
  logic [NUM_FIELDS-1:0] inc_reg;
  logic [NUM_FIELDS-1:0] inc_next;
  logic [IDLE_W-1:0]     idle_reg;
  logic [BLINK_W-1:0]    blink_cnt_reg;
  logic                  vis_reg;

  logic mode_level;
  logic mode_press;
  logic up_level;
  logic up_press;
  logic in_edit;
  logic state_change;
  logic up_fire;
  logic rep_fire;
  logic inc_fire;
  logic timeout_hit;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk   (clk),
    .rst_p (rst_p),
    .btn   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up_db (
    .clk   (clk),
    .rst_p (rst_p),
    .btn   (btn_up),
    .level (up_level),
    .press (up_press)
  );

  assign in_edit = (state_reg != ST_RUN);

  // Event decode: MODE outranks UP, and any press or increment defers the timeout.
  always_comb begin
    up_fire     = up_press & ~mode_press & in_edit;
    inc_fire    = up_fire | rep_fire;
    timeout_hit = in_edit & ~mode_press & ~up_press & ~inc_fire &
                  (idle_reg == IDLE_W'(TIMEOUT_CYC - 1));
    state_next  = state_reg;
    if (mode_press) begin
      state_next = next_field(state_reg);
    end else if (timeout_hit) begin
      state_next = ST_RUN;
    end
    state_change = (state_next != state_reg);
  end

  // Field state register with pause registered alongside it.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      state_reg <= ST_RUN;
      pause_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pause_reg <= (state_next != ST_RUN);
    end
  end

  // One inc line per field; only the line matching the current state can fire.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_inc
    assign inc_next[gi] = inc_fire && (state_reg == state_t'(gi + 1));
  end

  // Registered increment pulses, high for the single cycle after the event.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      inc_reg <= '0;
    end else begin
      inc_reg <= inc_next;
    end
  end

  // Idle timer: runs only in edit states, restarted by entry, presses and increments.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      idle_reg <= '0;
    end else if (!in_edit || state_change || mode_press || up_press || inc_fire) begin
      idle_reg <= '0;
    end else begin
      idle_reg <= idle_reg + IDLE_W'(1);
    end
  end

  // Blink timer: field visible in RUN, restarts visible on entry and on each increment.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      blink_cnt_reg <= '0;
      vis_reg       <= 1'b1;
    end else if (state_next == ST_RUN || state_change || inc_fire) begin
      blink_cnt_reg <= '0;
      vis_reg       <= 1'b1;
    end else if (blink_cnt_reg == BLINK_W'(BLINK_HALF_CYC - 1)) begin
      blink_cnt_reg <= '0;
      vis_reg       <= ~vis_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                : REPEAT_RATE_CYC;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic             rep_active_reg;
  logic             rep_first_reg;
  logic [REP_W-1:0] rep_cnt_reg;

  // rep_cnt counts cycles since the press (first repeat) or since the last repeat pulse.
  assign rep_fire = rep_active_reg & up_level & in_edit & ~mode_press &
                    (rep_first_reg ? (rep_cnt_reg == REP_W'(REPEAT_DELAY_CYC - 1))
                                   : (rep_cnt_reg == REP_W'(REPEAT_RATE_CYC - 1)));

  // Repeat timer: armed by an accepted UP press, cancelled by release or any state change.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b1;
      rep_cnt_reg    <= '0;
    end else if (mode_press || state_change || !up_level || !in_edit) begin
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b1;
      rep_cnt_reg    <= '0;
    end else if (up_fire) begin
      rep_active_reg <= 1'b1;
      rep_first_reg  <= 1'b1;
      rep_cnt_reg    <= REP_W'(1);
    end else if (rep_fire) begin
      rep_first_reg  <= 1'b0;
      rep_cnt_reg    <= '0;
    end else if (rep_active_reg) begin
      rep_cnt_reg    <= rep_cnt_reg + REP_W'(1);
    end
  end

  logic unused_levels;
  assign unused_levels = &{1'b0, mode_level};
`else
  assign rep_fire = 1'b0;

  // Held levels and repeat timing only matter when auto-repeat is built in.
  logic unused_levels;
  assign unused_levels = &{1'b0, mode_level, up_level,
                           REPEAT_DELAY_CYC[0], REPEAT_RATE_CYC[0]};
`endif

  assign pause     = pause_reg;
  assign sel_field = state_reg;
  assign field_vis = vis_reg;
  assign inc_sec   = inc_reg[0];
  assign inc_min   = inc_reg[1];
  assign inc_hour  = inc_reg[2];
  assign inc_day   = inc_reg[3];
  assign inc_month = inc_reg[4];
  assign inc_year  = inc_reg[5];

endmodule
